// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: counts edges of an asynchronous input over a 10^n-cycle gate
// and hands the saturated packed-BCD count to a valid/ready consumer.
module freq_meter_bcd #(
    parameter int DIGITS_NUM   = 6,
    parameter int GATE_DEC_MAX = 6
) (
    input  logic                    clk_in,
    input  logic                    rstn_in,
    input  logic                    sig_in,
    input  logic [2:0]              gate_sel_in,
    input  logic                    edge_both_in,
    input  logic                    hold_in,
    output logic [4*DIGITS_NUM-1:0] result_digits_out,
    output logic [2:0]              result_range_out,
    output logic                    overflow_out,
    output logic                    overrun_out,
    output logic                    result_valid_out,
    input  logic                    result_ready_in,
    output logic                    busy_out
);
    localparam int GW = $clog2(10**GATE_DEC_MAX + 1);
    localparam int DW = 4*DIGITS_NUM;

    typedef enum logic {IDLE, GATE} state_t;

    function automatic logic [GW-1:0] gate_last(input logic [2:0] e);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < GATE_DEC_MAX; i++)
            if (3'(i) < e) p = p * 32'd10;
        return GW'(p - 32'd1);
    endfunction

    state_t          state;
    logic            s1, s2, s3, pulse, all_nine, sat, sat_next, gate_done;
    logic [2:0]      sel_clamp, gate_len_exp;
    logic [GW-1:0]   gcnt, gate_end;
    logic [DW-1:0]   cnt, cnt_inc, cnt_next;

    assign sel_clamp = (gate_sel_in > 3'(GATE_DEC_MAX)) ? 3'(GATE_DEC_MAX) : gate_sel_in;
    assign pulse     = (s2 & ~s3) | (edge_both_in & ~s2 & s3);
    assign gate_done = (state == GATE) && (gcnt == gate_end);
    assign busy_out  = (state == GATE);

    // all_nine survives the ripple only when every digit was 9
    always_comb begin
        cnt_inc  = cnt;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS_NUM; i++)
            if (all_nine) begin
                if (cnt[4*i +: 4] == 4'd9) cnt_inc[4*i +: 4] = 4'd0;
                else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    all_nine = 1'b0;
                end
            end
    end

    assign cnt_next = (pulse & ~all_nine) ? cnt_inc : cnt;
    assign sat_next = sat | (pulse & all_nine);

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            {s1, s2, s3} <= 3'b000;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state             <= IDLE;
            gcnt              <= '0;
            gate_end          <= '0;
            gate_len_exp      <= '0;
            cnt               <= '0;
            sat               <= 1'b0;
            result_digits_out <= '0;
            result_range_out  <= '0;
            overflow_out      <= 1'b0;
            overrun_out       <= 1'b0;
            result_valid_out  <= 1'b0;
        end else begin
            // idle and the last gate cycle both (re)arm a fresh gate
            if (state == IDLE || gate_done) begin
                state        <= hold_in ? IDLE : GATE;
                gcnt         <= '0;
                cnt          <= '0;
                sat          <= 1'b0;
                gate_len_exp <= sel_clamp;
                gate_end     <= gate_last(sel_clamp);
            end else begin
                gcnt <= gcnt + GW'(1);
                cnt  <= cnt_next;
                sat  <= sat_next;
            end
            if (gate_done) begin
                result_digits_out <= cnt_next;
                overflow_out      <= sat_next;
                result_range_out  <= gate_len_exp;
                overrun_out       <= result_valid_out & ~result_ready_in;
                result_valid_out  <= 1'b1;
            end else if (result_valid_out && result_ready_in) begin
                result_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: doc/freq_meter_bcd.md
# freq_meter_bcd

Parametrised single-clock frequency meter. It counts edges of an asynchronous input over a selectable decade gate of reference-clock cycles and presents the count as packed BCD. Results go out through a valid/ready handshake to the display data streamer. It replaces a free-running prescaler and second-clock counter pair with a synchronised, saturating, back-to-back measurement engine.

## Interface
- DIGITS_NUM, 6: BCD digits in the event counter and the result.
- GATE_DEC_MAX, 6: largest gate exponent. The gate is 10^gate_sel cycles; 6 gives 1 s at a 1 MHz reference.
- clk_in  in  1  reference clock; the only clock.
- rstn_in  in  1  reset, asynchronous, active-low.
- sig_in  in  1  signal under measurement, asynchronous to clk_in.
- gate_sel_in  in  3  gate exponent. Values above GATE_DEC_MAX are clamped to GATE_DEC_MAX.
- edge_both_in  in  1  0 counts rising edges only; 1 counts rising and falling edges.
- hold_in  in  1  1 stops new gates from starting after the current gate ends.
- result_digits_out  out  4*DIGITS_NUM  latched count, packed BCD, digit 0 in bits [3:0].
- result_range_out  out  3  gate exponent actually used for the latched result.
- overflow_out  out  1  latched result saturated.
- overrun_out  out  1  the previous result was overwritten before it was accepted.
- result_valid_out  out  1  result registers hold an unaccepted result.
- result_ready_in  in  1  consumer accepts the result.
- busy_out  out  1  a gate is in progress (FSM in GATE).

## Operation
- **Input path:** sig_in passes through a 2-FF synchroniser (s1, s2), then one history register s3.
  - Rising pulse = s2 & ~s3.
  - Falling pulse = ~s2 & s3.
  - Edge pulse = rise, or (edge_both_in & fall).
  - All three registers reset to 0. If sig_in is high at reset release, that counts as one rising edge.
- **FSM states:**
  - IDLE → GATE when hold_in == 0. Gate counter and event counter are cleared; gate_sel_in (clamped) is sampled into gate_len_exp.
  - GATE: the binary gate counter runs 0 .. 10^gate_len_exp − 1. On its last cycle, the FSM captures.
  - Capture, then:
    - if hold_in == 1 → IDLE;
    - otherwise stay in GATE with both counters cleared and gate_sel_in re-sampled. There is no dead cycle between consecutive gates.
- **Event counter:** DIGITS_NUM-digit BCD. It increments on each edge pulse in GATE. Digits carry 9→0 into the next digit.
  - At all-9s, a further pulse leaves the count at all-9s and sets an internal sat flag.
  - sat clears with the counter.
- **Capture (one cycle):**
  - result_digits_out ← counter value including any pulse in that same cycle, saturated.
  - overflow_out ← sat, or the final pulse saturating.
  - result_range_out ← gate_len_exp.
  - overrun_out ← result_valid_out & ~result_ready_in.
  - result_valid_out ← 1.
- **Handshake:**
  - Transfer occurs on a cycle with result_valid_out & result_ready_in.
  - After a transfer with no coincident capture, result_valid_out clears next cycle.
  - A capture coincident with a transfer wins: valid stays 1, the new data loads, overrun_out = 0.
- **Input changes:**
  - gate_sel_in changes mid-gate have no effect until the next gate start.
  - edge_both_in is live and applies per cycle.
- **Reset mid-operation:** all state clears immediately. The pending result is lost; no output is asserted.

## Timing
- Reset values:
  - result_digits_out = 0, result_range_out = 0;
  - overflow_out, overrun_out, result_valid_out, busy_out = 0;
  - FSM = IDLE.
- First gate starts on the first clk_in edge after reset release with hold_in == 0. busy_out rises on that edge.
- sig_in edge to counter increment: the edge is counted on the 3rd clk_in rising edge after it is first sampled by s1.
- Gate length is exactly 10^gate_len_exp clk_in cycles. Captures of consecutive gates are exactly that many cycles apart.
- result_valid_out rises on the edge following the last gate cycle. Result registers are stable whenever valid = 1 and no capture occurs.
- Maximum countable rate: one edge pulse per 2 clk_in cycles (sig_in pulse widths ≥ 1 cycle plus synchroniser margin).

## Test plan
- **Basic count:** gate_sel=2, sig_in period 10 cycles, ready=1 → each result 0x000010, range 2, overflow 0; captures 100 cycles apart.
- **Both edges:** edge_both_in=1, same stimulus → 0x000020.
- **Saturation:** DIGITS_NUM=2, gate_sel=3, sig period 4 → 250 edges, result 0x99, overflow_out=1. The next gate with sig idle → 0x00, overflow 0.
- **Overrun:** ready held 0 across two captures → overrun_out=1 with the second gate's data. Ready=1 on the cycle of the third capture → overrun_out=0, valid stays 1.
- **Hold / range:** hold_in=1 mid-gate → one capture, then busy_out=0 and no further captures. Change gate_sel to 1, release hold → 10-cycle gates, range 1. gate_sel=7 clamps to range 6.
- **Reset mid-gate:** rstn_in low at cycle 50 of a 100-cycle gate → all outputs 0 asynchronously. After release, a full fresh 100-cycle gate runs.
